pipe_stage_reg: RTL

Parametrised elastic pipeline register for the RISCV32 core. It generalises the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. Features: configurable payload width, configurable chain depth, a valid/ready handshake, synchronous flush, and an optional skid buffer that removes the combinational ready path. It sits between any two pipeline stages and carries the packed stage struct as a flat vector.

---
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: DEPTH chained stages with valid/ready handshake,
// synchronous flush and an optional per-stage skid entry that registers ready.
module pipe_stage_reg #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter int               SKID      = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CAP       = DEPTH * (1 + SKID),
  localparam int              CW        = $clog2(CAP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Handshake: a transfer happens on an edge where valid && ready are both
  // high; valid must not depend on ready, and data is stable while valid waits.
  logic [DEPTH-1:0]            w_up_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_up_data;
  logic [DEPTH-1:0]            w_rdy;
  logic [DEPTH-1:0]            w_dn_rdy;
  logic [DEPTH-1:0]            w_mv;
  logic [DEPTH-1:0]            w_sv;
  logic [DEPTH-1:0][WIDTH-1:0] w_md;
  logic                        w_in_ready;
  logic [CW-1:0]               w_count;

  assign w_in_ready = w_rdy[0] && !flush && !rst;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign w_up_valid[i] = in_valid && w_in_ready;
      assign w_up_data[i]  = in_data;
    end else begin : g_mid
      assign w_up_valid[i] = w_mv[i-1];
      assign w_up_data[i]  = w_md[i-1];
    end

    if (i == DEPTH - 1) begin : g_last
      assign w_dn_rdy[i] = out_ready;
    end else begin : g_chain
      assign w_dn_rdy[i] = w_rdy[i+1];
    end

    if (SKID == 0) begin : g_plain
      logic             r_v;
      logic [WIDTH-1:0] r_d;
      logic             w_in;

      assign w_rdy[i] = !r_v || w_dn_rdy[i];
      assign w_in     = w_up_valid[i] && w_rdy[i];
      assign w_mv[i]  = r_v;
      assign w_sv[i]  = 1'b0;
      assign w_md[i]  = r_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
          r_d <= RESET_VAL;
        end else begin
          if (w_in) r_d <= w_up_data[i];
          if (flush) r_v <= 1'b0;
          else       r_v <= w_in || (r_v && !w_dn_rdy[i]);
        end
      end
    end else begin : g_skid
      logic             r_v;
      logic             r_s_v;
      logic [WIDTH-1:0] r_d;
      logic [WIDTH-1:0] r_s_d;
      logic             w_in;
      logic             w_take;

      // Ready comes straight from the skid flag, so no path from out_ready.
      assign w_rdy[i] = !r_s_v;
      assign w_in     = w_up_valid[i] && !r_s_v;
      assign w_take   = r_v && w_dn_rdy[i];
      assign w_mv[i]  = r_v;
      assign w_sv[i]  = r_s_v;
      assign w_md[i]  = r_d;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v   <= 1'b0;
          r_s_v <= 1'b0;
          r_d   <= RESET_VAL;
          r_s_d <= RESET_VAL;
        end else begin
          if (w_take && r_s_v)              r_d   <= r_s_d;
          else if (w_in && (w_take || !r_v)) r_d  <= w_up_data[i];
          else if (w_in)                    r_s_d <= w_up_data[i];

          if (flush) begin
            r_v   <= 1'b0;
            r_s_v <= 1'b0;
          end else if (w_take && r_s_v) begin
            r_s_v <= 1'b0;
          end else if (w_in) begin
            r_v <= 1'b1;
            if (r_v && !w_take) r_s_v <= 1'b1;
          end else if (w_take) begin
            r_v <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_count = w_count + CW'(w_mv[k]) + CW'(w_sv[k]);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_mv[DEPTH-1];
  assign out_data  = w_md[DEPTH-1];
  assign count     = w_count;

endmodule
